// File: rtl/cke_event_scheduler.sv
// -----------------------------------------------------------------------------
// cke_event_scheduler
//
// Shares one programmable clock-enable prescaler between pCh periodic timer
// channels. Every channel counts base ticks up to its own period and raises a
// pending flag when it expires. An arbiter hands one pending event at a time
// to the consumer over a valid/ready output register.
//
// Build option:
//   CKE_SCHED_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                         round-robin pointer not present.
//                            undefined -> round-robin starting at the pointer.
//
// Ports:
//   iSysClk    system clock
//   iSysRst    asynchronous active-low reset
//   iPrescale  base tick every iPrescale+1 cycles
//   iPeriod    packed per-channel periods in base ticks (0 acts as 1)
//   iChEn      per-channel enable
//   iOvfClr    per-channel clear of the sticky overflow flag
//   oTick      registered base tick pulse
//   oPend      pending flags
//   oOvf       sticky overflow flags (expiry while already pending)
//   oEvtValid  event presented
//   oEvtCh     channel index of the presented event
//   iEvtReady  consumer accepts the event
// -----------------------------------------------------------------------------
module cke_event_scheduler #(
  parameter int pCh         = 4,
  parameter int pDivWidth   = 16,
  parameter int pPerWidth   = 12,
  parameter int pChIdxWidth = 2
) (
  input  logic                     iSysClk,
  input  logic                     iSysRst,
  input  logic [pDivWidth-1:0]     iPrescale,
  input  logic [pCh*pPerWidth-1:0] iPeriod,
  input  logic [pCh-1:0]           iChEn,
  input  logic [pCh-1:0]           iOvfClr,
  output logic                     oTick,
  output logic [pCh-1:0]           oPend,
  output logic [pCh-1:0]           oOvf,
  output logic                     oEvtValid,
  output logic [pChIdxWidth-1:0]   oEvtCh,
  input  logic                     iEvtReady
);

  // Last count value of a period; a period of 0 behaves like 1.
  function automatic logic [pPerWidth-1:0] per_limit(input logic [pPerWidth-1:0] per);
    return (per == '0) ? '0 : per - 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Prescaler: the >= compare means lowering iPrescale below the current count
  // wraps immediately instead of counting all the way around.
  // ---------------------------------------------------------------------------
  logic [pDivWidth-1:0] cnt;
  logic                 tick;

  assign tick = (cnt >= iPrescale);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      cnt   <= '0;
      oTick <= 1'b0;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      oTick <= tick;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel tick counters
  // ---------------------------------------------------------------------------
  logic [pPerWidth-1:0] tcnt [pCh];
  logic [pCh-1:0]       expire;

  // NOTE: every always_comb output gets a default before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    expire = '0;
    for (int k = 0; k < pCh; k++) begin
      expire[k] = iChEn[k] && tick &&
                  (tcnt[k] >= per_limit(iPeriod[k*pPerWidth +: pPerWidth]));
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
  // like any other state to give a deterministic start.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      for (int k = 0; k < pCh; k++) tcnt[k] <= '0;
    end else begin
      for (int k = 0; k < pCh; k++) begin
        if (!iChEn[k])    tcnt[k] <= '0;
        else if (tick)    tcnt[k] <= expire[k] ? '0 : tcnt[k] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
  logic                   any_pend;
  logic                   load;
  logic [pChIdxWidth-1:0] winner;
  logic [pCh-1:0]         grant;

  assign any_pend = |oPend;
  assign load     = !oEvtValid || iEvtReady;

`ifdef CKE_SCHED_FIXED_PRIO_EN
  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = pCh - 1; i >= 0; i--) begin
      if (oPend[i]) winner = pChIdxWidth'(i);
    end
  end
`else
  logic [pChIdxWidth-1:0] ptr;
  logic [2*pCh-1:0]       pend_dbl;
  logic [pCh-1:0]         pend_rot;

  // Rotate pend so bit 0 is the pointer position; the first set bit of the
  // rotated vector is the round-robin winner.
  assign pend_dbl = {oPend, oPend} >> ptr;
  assign pend_rot = pend_dbl[pCh-1:0];

  always_comb begin
    int  pos;
    logic found;
    winner = ptr;
    found  = 1'b0;
    pos    = 0;
    for (int i = 0; i < pCh; i++) begin
      if (!found && pend_rot[i]) begin
        found = 1'b1;
        pos   = int'(ptr) + i;
        if (pos >= pCh) pos = pos - pCh;
        winner = pChIdxWidth'(pos);
      end
    end
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      ptr <= '0;
    end else if (load && any_pend) begin
      ptr <= (int'(winner) == pCh - 1) ? '0 : winner + 1'b1;
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (load && any_pend) grant[winner] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Pending / overflow flags and output register. A grant in the same cycle as
  // an expiry keeps pend set without an overflow; disabled channels drop their
  // pend but an event already in the output register stays.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      oPend     <= '0;
      oOvf      <= '0;
      oEvtValid <= 1'b0;
      oEvtCh    <= '0;
    end else begin
      oPend <= iChEn & ((oPend & ~grant) | expire);
      oOvf  <= (oOvf & ~iOvfClr) | (expire & oPend & ~grant);
      if (load) begin
        oEvtValid <= any_pend;
        if (any_pend) oEvtCh <= winner;
      end
    end
  end

endmodule
